// File: rtl/execute_mdu_pkg.sv
// Shared types for the EX stage: ALU, branch, PC-source and multiply/divide encodings,
// plus small decode helpers for the multiply/divide unit.
package execute_mdu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
   } br_func_t;

   typedef enum logic [1:0] {
      PC_INC, PC_BR, PC_JAL
   } pc_source_t;

   typedef enum logic [3:0] {
      MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE, MD_BUSY, MD_DONE
   } md_state_t;

   function automatic logic md_is_div(md_op_t op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_rem(md_op_t op);
      return op inside {MD_REM, MD_REMU};
   endfunction

   function automatic logic md_signed_a(md_op_t op);
      return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic md_signed_b(md_op_t op);
      return op inside {MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// ID/EX inputs and EX outputs of the execute stage bundled as one interface;
// master drives the instruction, slave is the EX stage.
interface execute_mdu_if
   import execute_mdu_pkg::*;
   #(parameter int XLEN = 32)
   ();

   logic             ex_valid;
   logic             ex_kill;
   logic             ex_ALU_imm;
   logic             ex_ALU_pc;
   alu_ctrl_t        ex_ALU_ctrl;
   md_op_t           ex_md_op;
   logic             ex_JAL_addr;
   pc_source_t       ex_pc_source;
   br_func_t         ex_br_func;
   logic [1:0]       ex_forward_rs1;
   logic [1:0]       ex_forward_rs2;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_m_data;
   logic [XLEN-1:0]  ex_w_data;

   logic [XLEN-1:0]  ex_alu_out;
   logic [XLEN-1:0]  ex_pc_inc_out;
   logic [XLEN-1:0]  ex_mem_data;
   logic [XLEN-1:0]  ex_br_jal_addr;
   logic             takeBranch;
   logic             ex_stall;

   modport master (
      output ex_valid, ex_kill, ex_ALU_imm, ex_ALU_pc, ex_ALU_ctrl, ex_md_op,
             ex_JAL_addr, ex_pc_source, ex_br_func, ex_forward_rs1, ex_forward_rs2,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_m_data, ex_w_data,
      input  ex_alu_out, ex_pc_inc_out, ex_mem_data, ex_br_jal_addr, takeBranch, ex_stall
   );

   modport slave (
      input  ex_valid, ex_kill, ex_ALU_imm, ex_ALU_pc, ex_ALU_ctrl, ex_md_op,
             ex_JAL_addr, ex_pc_source, ex_br_func, ex_forward_rs1, ex_forward_rs2,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_m_data, ex_w_data,
      output ex_alu_out, ex_pc_inc_out, ex_mem_data, ex_br_jal_addr, takeBranch, ex_stall
   );

endinterface

// File: rtl/execute_mdu_md_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, MD_UNROLL bits per cycle, sign fix-up in the DONE cycle.
//   state   | meaning
//   MD_IDLE | waiting for start; operands and sign flags latched on start
//   MD_BUSY | retiring MD_UNROLL bits per cycle until the counter reaches 0
//   MD_DONE | result valid for one cycle, then back to idle
module md_unit
   import execute_mdu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  md_op_t          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int STEPS = XLEN / MD_UNROLL;
   localparam int CW    = $clog2(STEPS) + 1;

   md_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   md_op_t            op_q, op_d;
   logic              neg_q, neg_d;
   logic              dz_q, dz_d;

   logic              sa, sb;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN:0]     part;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      sa    = md_signed_a(op) & a[XLEN-1];
      sb    = md_signed_b(op) & b[XLEN-1];
      a_mag = sa ? -a : a;
      b_mag = sb ? -b : b;
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      acc_step = acc_q;
      part     = '0;
      for (int i = 0; i < MD_UNROLL; i++) begin
         if (md_is_div(op_q)) begin
            part = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
            if (part >= {1'b0, b_q}) begin
               part     = part - {1'b0, b_q};
               acc_step = {part[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
            end else begin
               acc_step = {part[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
            end
         end else begin
            part     = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, b_q} : '0);
            acc_step = {part, acc_step[XLEN-1:1]};
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      op_d    = op_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = CW'(STEPS);
               acc_d   = {{XLEN{1'b0}}, a_mag};
               b_d     = b_mag;
               op_d    = op;
               neg_d   = md_is_rem(op) ? sa : (sa ^ sb);
               dz_d    = (b == '0);
            end
         end
         MD_BUSY: begin
            if (kill) begin
               state_d = MD_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = MD_DONE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         op_q    <= MD_NONE;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = (state_q == MD_BUSY);
   assign done = (state_q == MD_DONE);

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo      = acc_q[XLEN-1:0];
      rem      = acc_q[2*XLEN-1:XLEN];
      result   = '0;
      if (done) begin
         case (op_q)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = dz_q ? '1 : (neg_q ? -quo : quo);
            MD_REM, MD_REMU:              result = neg_q ? -rem : rem;
            default:                      result = '0;
         endcase
      end
   end

endmodule

// File: rtl/execute_mdu.sv
// RV32 EX stage: operand forwarding, ALU, branch/JAL redirect, and the iterative
// multiply/divide unit whose issue and busy cycles stall the pipeline.
module execute_mdu
   import execute_mdu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   execute_mdu_if.slave ex_if
);

   localparam int SW = $clog2(XLEN);

   logic [XLEN-1:0] rs1_f, rs2_f, op1, op2, alu_res, target, md_result;
   logic            br_cond, take, is_md, md_start, md_busy, md_done;

   always_comb begin
      case (ex_if.ex_forward_rs1)
         2'b00:   rs1_f = ex_if.ex_m_data;
         2'b01:   rs1_f = ex_if.ex_w_data;
         default: rs1_f = ex_if.ex_rs1_data;
      endcase
      case (ex_if.ex_forward_rs2)
         2'b00:   rs2_f = ex_if.ex_m_data;
         2'b01:   rs2_f = ex_if.ex_w_data;
         default: rs2_f = ex_if.ex_rs2_data;
      endcase
      op1 = ex_if.ex_ALU_pc  ? ex_if.ex_pc  : rs1_f;
      op2 = ex_if.ex_ALU_imm ? ex_if.ex_imm : rs2_f;
   end

   always_comb begin
      case (ex_if.ex_ALU_ctrl)
         ALU_ADD:  alu_res = op1 + op2;
         ALU_SUB:  alu_res = op1 - op2;
         ALU_SLL:  alu_res = op1 << op2[SW-1:0];
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
         ALU_XOR:  alu_res = op1 ^ op2;
         ALU_SRL:  alu_res = op1 >> op2[SW-1:0];
         ALU_SRA:  alu_res = $unsigned($signed(op1) >>> op2[SW-1:0]);
         ALU_OR:   alu_res = op1 | op2;
         ALU_AND:  alu_res = op1 & op2;
         ALU_PASS: alu_res = op2;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      case (ex_if.ex_br_func)
         BR_BEQ:  br_cond = (rs1_f == rs2_f);
         BR_BNE:  br_cond = (rs1_f != rs2_f);
         BR_BLT:  br_cond = ($signed(rs1_f) <  $signed(rs2_f));
         BR_BGE:  br_cond = ($signed(rs1_f) >= $signed(rs2_f));
         BR_BLTU: br_cond = (rs1_f <  rs2_f);
         BR_BGEU: br_cond = (rs1_f >= rs2_f);
         default: br_cond = 1'b0;
      endcase
   end

   // MD instructions never redirect, so their target and request stay 0
   always_comb begin
      is_md  = (ex_if.ex_md_op != MD_NONE);
      target = '0;
      take   = 1'b0;
      if (!is_md) begin
         case (ex_if.ex_pc_source)
            PC_BR: begin
               target = ex_if.ex_pc + ex_if.ex_imm;
               take   = br_cond;
            end
            PC_JAL: begin
               target = ex_if.ex_JAL_addr ? ((rs1_f + ex_if.ex_imm) & ~XLEN'(1))
                                          : (ex_if.ex_pc + ex_if.ex_imm);
               take   = 1'b1;
            end
            default: target = '0;
         endcase
      end
   end

   assign md_start = ex_if.ex_valid & ~ex_if.ex_kill & is_md & ~rst;

   md_unit #(.XLEN(XLEN), .MD_UNROLL(MD_UNROLL)) u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .op     (ex_if.ex_md_op),
      .a      (rs1_f),
      .b      (rs2_f),
      .kill   (ex_if.ex_kill),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   assign ex_if.ex_alu_out     = md_done ? md_result : alu_res;
   assign ex_if.ex_pc_inc_out  = ex_if.ex_pc + XLEN'(4);
   assign ex_if.ex_mem_data    = rs2_f;
   assign ex_if.ex_br_jal_addr = target;
   assign ex_if.takeBranch     = take & ex_if.ex_valid & ~ex_if.ex_kill & ~rst;
   assign ex_if.ex_stall       = ~rst & ((md_start & ~md_busy & ~md_done) | md_busy);

endmodule

// File: tb/tb_execute_mdu.sv
// Bench for execute_mdu: two instances (MD_UNROLL 1 and 4) checked against a plain
// arithmetic reference model for ALU, branch redirect and RV32M results.
module tb_execute_mdu;
   import execute_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst, valid1, valid4, kill, alu_imm, alu_pc, jal_addr;
   alu_ctrl_t  alu_ctrl;
   md_op_t     md_op;
   pc_source_t pc_src;
   br_func_t   br_func;
   logic [1:0]  fwd1, fwd2;
   logic [31:0] rs1, rs2, imm, pc, mdata, wdata;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   execute_mdu_if #(.XLEN(32)) if1 ();
   execute_mdu_if #(.XLEN(32)) if4 ();

   assign if1.ex_valid = valid1;          assign if4.ex_valid = valid4;
   assign if1.ex_kill = kill;             assign if4.ex_kill = kill;
   assign if1.ex_ALU_imm = alu_imm;       assign if4.ex_ALU_imm = alu_imm;
   assign if1.ex_ALU_pc = alu_pc;         assign if4.ex_ALU_pc = alu_pc;
   assign if1.ex_ALU_ctrl = alu_ctrl;     assign if4.ex_ALU_ctrl = alu_ctrl;
   assign if1.ex_md_op = md_op;           assign if4.ex_md_op = md_op;
   assign if1.ex_JAL_addr = jal_addr;     assign if4.ex_JAL_addr = jal_addr;
   assign if1.ex_pc_source = pc_src;      assign if4.ex_pc_source = pc_src;
   assign if1.ex_br_func = br_func;       assign if4.ex_br_func = br_func;
   assign if1.ex_forward_rs1 = fwd1;      assign if4.ex_forward_rs1 = fwd1;
   assign if1.ex_forward_rs2 = fwd2;      assign if4.ex_forward_rs2 = fwd2;
   assign if1.ex_rs1_data = rs1;          assign if4.ex_rs1_data = rs1;
   assign if1.ex_rs2_data = rs2;          assign if4.ex_rs2_data = rs2;
   assign if1.ex_imm = imm;               assign if4.ex_imm = imm;
   assign if1.ex_pc = pc;                 assign if4.ex_pc = pc;
   assign if1.ex_m_data = mdata;          assign if4.ex_m_data = mdata;
   assign if1.ex_w_data = wdata;          assign if4.ex_w_data = wdata;

   execute_mdu #(.XLEN(32), .MD_UNROLL(1)) dut1 (.clk(clk), .rst(rst), .ex_if(if1));
   execute_mdu #(.XLEN(32), .MD_UNROLL(4)) dut4 (.clk(clk), .rst(rst), .ex_if(if4));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] fwd_ref(logic [1:0] c, logic [31:0] m, w, r);
      return (c == 2'b00) ? m : (c == 2'b01) ? w : r;
   endfunction

   function automatic logic [31:0] alu_ref(alu_ctrl_t c, logic [31:0] x, y);
      case (c)
         ALU_ADD:  return x + y;
         ALU_SUB:  return x - y;
         ALU_SLL:  return x << y[4:0];
         ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
         ALU_XOR:  return x ^ y;
         ALU_SRL:  return x >> y[4:0];
         ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
         ALU_OR:   return x | y;
         ALU_AND:  return x & y;
         ALU_PASS: return y;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic br_ref(br_func_t f, logic [31:0] x, y);
      case (f)
         BR_BEQ:  return x == y;
         BR_BNE:  return x != y;
         BR_BLT:  return $signed(x) < $signed(y);
         BR_BGE:  return $signed(x) >= $signed(y);
         BR_BLTU: return x < y;
         BR_BGEU: return x >= y;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] md_ref(md_op_t op, logic [31:0] a, b);
      logic [63:0] p;
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
         MD_MULH:   begin p = sa * sb;                 return p[63:32]; end
         MD_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         MD_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         MD_DIV:    begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         MD_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         MD_REM:    begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         MD_REMU:   return (b == 32'd0) ? a : a % b;
         default:   return 32'd0;
      endcase
   endfunction

   function automatic logic stall_of(int sel);
      return (sel == 4) ? if4.ex_stall : if1.ex_stall;
   endfunction

   // Issue one MD op on the selected instance, scramble every forwarding source after
   // the issue cycle, and check latency, result and the absence of a redirect.
   task automatic run_md(input int sel, input md_op_t op, input logic [31:0] a, b,
                         input int f1, input string tag);
      int lat = 0;
      int exp_lat = (sel == 4) ? 10 : 34;
      bit seen = 0;
      logic [31:0] res = 'x, tgt = 'x;
      logic tb = 1'bx;
      fwd1 = (f1 >= 0) ? 2'(f1) : 2'($urandom_range(0, 3));
      fwd2 = fwd1[1] ? 2'($urandom_range(0, 3)) : {1'b1, 1'($urandom_range(0, 1))};
      rs1 = $urandom; rs2 = $urandom; mdata = $urandom; wdata = $urandom;
      if (fwd1 == 2'b00) mdata = a; else if (fwd1 == 2'b01) wdata = a; else rs1 = a;
      if (fwd2 == 2'b00) mdata = b; else if (fwd2 == 2'b01) wdata = b; else rs2 = b;
      md_op = op; pc_src = PC_JAL; jal_addr = 1'b0; kill = 1'b0;
      valid1 = (sel == 1); valid4 = (sel == 4);
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         lat++;
         if (!stall_of(sel)) begin
            seen = 1;
            res = (sel == 4) ? if4.ex_alu_out : if1.ex_alu_out;
            tb  = (sel == 4) ? if4.takeBranch : if1.takeBranch;
            tgt = (sel == 4) ? if4.ex_br_jal_addr : if1.ex_br_jal_addr;
         end else begin
            tick();
            rs1 = $urandom; rs2 = $urandom; mdata = $urandom; wdata = $urandom;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, res, md_ref(op, a, b));
      check({tag, "_no_redirect"}, {31'd0, tb}, 32'd0);
      check({tag, "_target"}, tgt, 32'd0);
      tick();
      valid1 = 1'b0; valid4 = 1'b0; md_op = MD_NONE; pc_src = PC_INC;
   endtask

   initial begin
      logic [31:0] x, y, exp_t, corner [5];
      logic exp_tb;
      int stalls;
      corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

      rst = 1'b1; valid1 = 1'b1; valid4 = 1'b1; kill = 1'b0; alu_imm = 1'b0; alu_pc = 1'b0;
      jal_addr = 1'b0; alu_ctrl = ALU_ADD; md_op = MD_NONE; pc_src = PC_JAL; br_func = BR_NONE;
      fwd1 = 2'b10; fwd2 = 2'b10; rs1 = 32'd3; rs2 = 32'd4; imm = 32'd8; pc = 32'h100;
      mdata = 32'd0; wdata = 32'd0;
      @(negedge clk);
      check("reset_takeBranch", {31'd0, if1.takeBranch}, 32'd0);
      tick();
      md_op = MD_DIV;
      @(negedge clk);
      check("reset_stall", {31'd0, if1.ex_stall}, 32'd0);
      check("reset_stall_u4", {31'd0, if4.ex_stall}, 32'd0);
      tick();
      rst = 1'b0; valid1 = 1'b0; valid4 = 1'b0; md_op = MD_NONE; pc_src = PC_INC;
      @(negedge clk);
      check("idle_stall", {31'd0, if1.ex_stall}, 32'd0);
      check("idle_add", if1.ex_alu_out, 32'd7);
      check("pc_inc_target", if1.ex_br_jal_addr, 32'd0);

      // BLTU is strictly unsigned less-than
      tick();
      valid1 = 1'b1; pc_src = PC_BR; br_func = BR_BLTU; rs1 = 32'd5; rs2 = 32'd5;
      imm = 32'h20; pc = 32'h100;
      @(negedge clk);
      check("bltu_equal", {31'd0, if1.takeBranch}, 32'd0);
      tick();
      rs1 = 32'd4;
      @(negedge clk);
      check("bltu_less", {31'd0, if1.takeBranch}, 32'd1);
      check("bltu_target", if1.ex_br_jal_addr, 32'h120);

      for (int i = 0; i < 40; i++) begin
         tick();
         valid1 = 1'b1; kill = ($urandom_range(0, 5) == 0); md_op = MD_NONE;
         alu_ctrl = alu_ctrl_t'(4'($urandom_range(0, 10)));
         alu_imm = 1'($urandom_range(0, 1)); alu_pc = 1'($urandom_range(0, 1));
         jal_addr = 1'($urandom_range(0, 1));
         pc_src = pc_source_t'(2'($urandom_range(0, 2)));
         br_func = br_func_t'(3'($urandom_range(0, 6)));
         fwd1 = 2'($urandom_range(0, 3)); fwd2 = 2'($urandom_range(0, 3));
         rs1 = $urandom; rs2 = $urandom; mdata = $urandom; wdata = $urandom;
         imm = $urandom; pc = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) begin rs2 = rs1; mdata = rs1; wdata = rs1; end
         @(negedge clk);
         x = fwd_ref(fwd1, mdata, wdata, rs1);
         y = fwd_ref(fwd2, mdata, wdata, rs2);
         exp_t  = (pc_src == PC_BR)  ? pc + imm :
                  (pc_src == PC_JAL) ? (jal_addr ? ((x + imm) & 32'hFFFF_FFFE) : pc + imm) : 32'd0;
         exp_tb = !kill && ((pc_src == PC_JAL) || (pc_src == PC_BR && br_ref(br_func, x, y)));
         check("rand_alu", if1.ex_alu_out, alu_ref(alu_ctrl, alu_pc ? pc : x, alu_imm ? imm : y));
         check("rand_mem_data", if1.ex_mem_data, y);
         check("rand_pc_inc", if1.ex_pc_inc_out, pc + 32'd4);
         check("rand_target", if1.ex_br_jal_addr, exp_t);
         check("rand_takeBranch", {31'd0, if1.takeBranch}, {31'd0, exp_tb});
      end
      tick();
      valid1 = 1'b0; kill = 1'b0; alu_imm = 1'b0; alu_pc = 1'b0; alu_ctrl = ALU_ADD;

      for (int s = 0; s < 2; s++) begin
         run_md(s ? 4 : 1, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
         run_md(s ? 4 : 1, MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, -1, "rem_ovf");
         run_md(s ? 4 : 1, MD_DIVU,  32'd7, 32'd0, -1, "divu_by0");
         run_md(s ? 4 : 1, MD_REMU,  32'd7, 32'd0, -1, "remu_by0");
         run_md(s ? 4 : 1, MD_DIV,   32'hFFFF_FFF9, 32'd0, -1, "div_neg_by0");
         run_md(s ? 4 : 1, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "mulhu_max");
         run_md(s ? 4 : 1, MD_MULH,  32'hFFFF_FFFD, 32'd5, 0, "mulh_fwd_m");
      end

      for (int i = 0; i < 16; i++) begin
         x = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         y = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
         run_md(i[0] ? 4 : 1, md_op_t'(4'($urandom_range(1, 8))), x, y, -1, "rand_md");
      end

      // kill on BUSY cycle 10, then an ordinary ADD
      tick();
      fwd1 = 2'b10; fwd2 = 2'b10; rs1 = 32'd100; rs2 = 32'd7; md_op = MD_DIV; valid1 = 1'b1;
      @(negedge clk);
      check("kill_issue_stall", {31'd0, if1.ex_stall}, 32'd1);
      for (int c = 0; c < 10; c++) tick();
      kill = 1'b1;
      @(negedge clk);
      check("kill_cycle_stall", {31'd0, if1.ex_stall}, 32'd1);
      tick();
      kill = 1'b0; md_op = MD_NONE; alu_ctrl = ALU_ADD; rs1 = 32'd11; rs2 = 32'd22;
      @(negedge clk);
      check("kill_next_stall", {31'd0, if1.ex_stall}, 32'd0);
      check("kill_then_add", if1.ex_alu_out, 32'd33);
      tick();
      valid1 = 1'b0;
      stalls = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (if1.ex_stall) stalls++;
      end
      check("kill_no_resume", 32'(stalls), 32'd0);

      // kill in idle suppresses issue
      tick();
      valid1 = 1'b1; md_op = MD_MUL; kill = 1'b1;
      @(negedge clk);
      check("kill_idle_stall", {31'd0, if1.ex_stall}, 32'd0);
      tick();
      valid1 = 1'b0; kill = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      check("kill_idle_no_issue", {31'd0, if1.ex_stall}, 32'd0);

      // reset mid-BUSY
      tick();
      valid1 = 1'b1; valid4 = 1'b1; md_op = MD_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3;
      for (int c = 0; c < 6; c++) tick();
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy_stall", {31'd0, if1.ex_stall}, 32'd0);
      tick();
      rst = 1'b0; valid1 = 1'b0; valid4 = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      check("rst_idle_stall", {31'd0, if1.ex_stall}, 32'd0);
      check("rst_idle_stall_u4", {31'd0, if4.ex_stall}, 32'd0);
      tick();
      run_md(1, MD_REM, 32'hFFFF_FFF9, 32'd2, -1, "rem_after_rst");
      run_md(4, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "mulhsu_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
